// File: rtl/cpu_dcache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
package cpu_dcache_pkg;

    localparam int PHYSICAL_ADDR_WIDTH = 20;
    localparam int WORD_BITS           = 32;
    localparam int LINE_WIDTH          = 128;
    localparam int OFFSET_BITS         = 4;
    localparam int INDEX_BITS          = 2;
    localparam int INDEX_LSB           = OFFSET_BITS;
    localparam int TAG_LSB             = OFFSET_BITS + INDEX_BITS;

    localparam logic MODE_WORD = 1'b0;
    localparam logic MODE_BYTE = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } dcache_state_t;

endpackage

// File: rtl/cpu_dcache_line_sel.sv
// Word/byte extract from a cache line for reads, and word/byte merge into it for writes.
module cpu_dcache_line_sel
    import cpu_dcache_pkg::*;
#(
    parameter int LINE_BITS = LINE_WIDTH
) (
    input  logic [LINE_BITS-1:0]   line,
    input  logic [OFFSET_BITS-1:0] offset,
    input  logic                   mode,
    input  logic [WORD_BITS-1:0]   wdata,
    output logic [WORD_BITS-1:0]   rdata,
    output logic [LINE_BITS-1:0]   merged
);

    logic [1:0]           word_sel;
    logic [WORD_BITS-1:0] rword;
    logic [7:0]           rbyte;

    always_comb begin
        word_sel = offset[3:2];
        rword    = line[{word_sel, 5'b0} +: WORD_BITS];
        rbyte    = line[{offset, 3'b0} +: 8];
        rdata    = (mode == MODE_BYTE) ? {24'b0, rbyte} : rword;
        merged   = line;
        if (mode == MODE_BYTE) begin
            merged[{offset, 3'b0} +: 8] = wdata[7:0];
        end else begin
            merged[{word_sel, 5'b0} +: WORD_BITS] = wdata;
        end
    end

endmodule

// File: rtl/cpu_dcache.sv
// Direct-mapped write-back, write-allocate data cache with bus-granted line fill/evict.
// Define CPU_DCACHE_TRACE_EN to print a per-request trace line.
module cpu_dcache
    import cpu_dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = PHYSICAL_ADDR_WIDTH,
    parameter int LINE_BITS  = LINE_WIDTH,
    parameter int NUM_LINES  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic                  req_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_BITS-1:0]  req_data,
    output logic                  resp_hit,
    output logic [WORD_BITS-1:0]  resp_data,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    input  logic                  mem_bus_available,
    output logic                  mem_req_read,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_BITS-1:0]  mem_req_data,
    input  logic                  mem_resp_valid,
    input  logic [LINE_BITS-1:0]  mem_resp_data,
    output dcache_state_t         state_dbg
);

    localparam int TAG_BITS = ADDR_WIDTH - TAG_LSB;

    // Handshake: req_read/req_write are held until resp_hit; mem_req_* are
    // offered only while mem_bus_available, and mem_resp_valid ends the transfer.
    dcache_state_t         state;
    logic [NUM_LINES-1:0]  valid;
    logic [NUM_LINES-1:0]  dirty;
    logic [TAG_BITS-1:0]   tags  [NUM_LINES];
    logic [LINE_BITS-1:0]  lines [NUM_LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  req_any;
    logic                  tag_hit;
    logic [WORD_BITS-1:0]  sel_rdata;
    logic [LINE_BITS-1:0]  merged_line;

    assign req_idx   = req_addr[TAG_LSB-1:INDEX_LSB];
    assign req_tag   = req_addr[ADDR_WIDTH-1:TAG_LSB];
    assign req_any   = req_read | req_write;
    assign tag_hit   = valid[req_idx] && (tags[req_idx] == req_tag);
    assign resp_hit  = req_any && tag_hit && (state == IDLE);
    assign resp_data = resp_hit ? sel_rdata : '0;
    assign resp_addr = req_addr;
    assign state_dbg = state;

    assign mem_req_write = (state == WRITEBACK) && mem_bus_available;
    assign mem_req_read  = (state == FILL) && mem_bus_available;

    cpu_dcache_line_sel #(
        .LINE_BITS (LINE_BITS)
    ) u_line_sel (
        .line   (lines[req_idx]),
        .offset (req_addr[OFFSET_BITS-1:0]),
        .mode   (req_mode),
        .wdata  (req_data),
        .rdata  (sel_rdata),
        .merged (merged_line)
    );

    // The miss set/tag are latched so a dropped request cannot disturb the transfer.
    always_comb begin
        mem_req_addr = '0;
        mem_req_data = '0;
        if (state == WRITEBACK) begin
            mem_req_addr = {tags[miss_idx], miss_idx, {OFFSET_BITS{1'b0}}};
            mem_req_data = lines[miss_idx];
        end else if (state == FILL) begin
            mem_req_addr = {miss_tag, miss_idx, {OFFSET_BITS{1'b0}}};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            valid    <= '0;
            dirty    <= '0;
            miss_idx <= '0;
            miss_tag <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tags[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (resp_hit) begin
                        if (req_write) begin
                            dirty[req_idx] <= 1'b1;
                        end
                    end else if (req_any) begin
                        miss_idx <= req_idx;
                        miss_tag <= req_tag;
                        state    <= (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_resp_valid) begin
                        dirty[miss_idx] <= 1'b0;
                        state           <= FILL;
                    end
                end
                FILL: begin
                    if (mem_resp_valid) begin
                        valid[miss_idx] <= 1'b1;
                        dirty[miss_idx] <= 1'b0;
                        tags[miss_idx]  <= miss_tag;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage carries no reset; valid bits gate every use of it.
    always_ff @(posedge clock) begin
        if (resp_hit && req_write) begin
            lines[req_idx] <= merged_line;
        end else if ((state == FILL) && mem_resp_valid) begin
            lines[miss_idx] <= mem_resp_data;
        end
    end

`ifdef CPU_DCACHE_TRACE_EN
    always_ff @(posedge clock) begin
        if (req_any) begin
            $display("dcache addr=%h hit=%b data=%h state=%s bus=%b mem_rd=%b mem_valid=%b",
                     req_addr, resp_hit, resp_data, state.name(), mem_bus_available,
                     mem_req_read, mem_resp_valid);
        end
    end
`else
`endif

endmodule

// File: tb/tb_cpu_dcache.sv
// Self-checking bench for cpu_dcache: directed scenarios plus randomized traffic against a memory model.
module tb_cpu_dcache;
  import cpu_dcache_pkg::*;

  localparam int AW = 20;

  logic          clock;
  logic          reset;
  logic          req_read;
  logic          req_write;
  logic          req_mode;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic          resp_hit;
  logic [31:0]   resp_data;
  logic [AW-1:0] resp_addr;
  logic          mem_bus_available;
  logic          mem_req_read;
  logic          mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [127:0]  mem_req_data;
  logic          mem_resp_valid;
  logic [127:0]  mem_resp_data;
  dcache_state_t state_dbg;

  cpu_dcache dut (
    .clock             (clock),
    .reset             (reset),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_mode          (req_mode),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .resp_hit          (resp_hit),
    .resp_data         (resp_data),
    .resp_addr         (resp_addr),
    .mem_bus_available (mem_bus_available),
    .mem_req_read      (mem_req_read),
    .mem_req_write     (mem_req_write),
    .mem_req_addr      (mem_req_addr),
    .mem_req_data      (mem_req_data),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data),
    .state_dbg         (state_dbg)
  );

  // ---------------- model state ----------------
  logic [127:0] arch_mem [int];   // what the CPU must observe, keyed by line address
  logic [127:0] backing  [int];   // what main memory actually holds
  logic         res_valid [4];
  logic [13:0]  res_tag   [4];
  logic         res_dirty [4];
  int           checks = 0;
  int           errors = 0;
  bit           bus_off = 0;
  bit           bus_rand = 0;
  bit           stall = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got time %0t required earlier end", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ensure(int la);
    logic [127:0] v;
    if (!arch_mem.exists(la)) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      arch_mem[la] = v;
      backing[la]  = v;
    end
  endfunction

  function automatic logic [31:0] line_read(logic [127:0] ln, logic m, logic [3:0] off);
    int sh;
    if (m) begin
      sh = int'(off) * 8;
      return {24'b0, ln[sh +: 8]};
    end
    sh = int'(off[3:2]) * 32;
    return ln[sh +: 32];
  endfunction

  function automatic void clear_residency();
    for (int i = 0; i < 4; i++) begin
      res_valid[i] = 1'b0;
      res_tag[i]   = '0;
      res_dirty[i] = 1'b0;
    end
  endfunction

  // ---------------- memory responder ----------------
  initial begin : responder
    int dly;
    int kind;
    int pla;
    logic [127:0] pdata;
    dly = 0; kind = 0; pla = 0; pdata = '0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    mem_bus_available = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (mem_resp_valid && reset) begin
        if (kind == 1) begin
          backing[pla] = pdata;
          res_dirty[pla & 3] = 1'b0;
        end else if (kind == 2) begin
          res_valid[pla & 3] = 1'b1;
          res_tag[pla & 3]   = 14'(pla >> 2);
          res_dirty[pla & 3] = 1'b0;
        end
      end
      mem_resp_valid = 1'b0;
      kind = 0;
      mem_bus_available = bus_off ? 1'b0 : (bus_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      #1;
      if (reset && !stall && (mem_req_read || mem_req_write)) begin
        if (dly == 0) begin
          pla = int'(mem_req_addr >> 4);
          if (mem_req_write) begin
            kind = 1;
            pdata = mem_req_data;
          end else begin
            kind = 2;
            ensure(pla);
            mem_resp_data = backing[pla];
          end
          mem_resp_valid = 1'b1;
          dly = $urandom_range(0, 3);
        end else begin
          dly--;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    int set;
    int la;
    int vla;
    int off;
    logic [13:0] tag;
    logic exp_hit;
    logic [127:0] ln;
    forever begin
      @(negedge clock);
      if (reset) begin
        check("resp_addr", resp_addr, req_addr);
        if (!mem_bus_available) begin
          check("rd_gated", mem_req_read, 1'b0);
          check("wr_gated", mem_req_write, 1'b0);
        end
        if (req_read || req_write) begin
          la  = int'(req_addr >> 4);
          set = la & 3;
          tag = req_addr[19:6];
          exp_hit = res_valid[set] && (res_tag[set] == tag);
          check("resp_hit", resp_hit, exp_hit);
          if (exp_hit && req_read) begin
            ensure(la);
            check("resp_data", resp_data, line_read(arch_mem[la], req_mode, req_addr[3:0]));
          end
          if (exp_hit && req_write) begin
            ensure(la);
            ln = arch_mem[la];
            if (req_mode) begin
              off = int'(req_addr[3:0]) * 8;
              ln[off +: 8] = req_data[7:0];
            end else begin
              off = int'(req_addr[3:2]) * 32;
              ln[off +: 32] = req_data;
            end
            arch_mem[la] = ln;
            res_dirty[set] = 1'b1;
          end
          if (mem_req_write) begin
            vla = int'(res_tag[set]) * 4 + set;
            ensure(vla);
            check("wb_needed", res_valid[set] && res_dirty[set], 1'b1);
            check("wb_addr", mem_req_addr, {res_tag[set], set[1:0], 4'h0});
            check("wb_data", mem_req_data, arch_mem[vla]);
          end
          if (mem_req_read) begin
            check("fill_clean", res_valid[set] && res_dirty[set], 1'b0);
            check("fill_addr", mem_req_addr, {req_addr[19:4], 4'h0});
          end
        end else begin
          check("idle_hit", resp_hit, 1'b0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic w, input logic m, input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge clock); #3;
    req_read  = !w;
    req_write = w;
    req_mode  = m;
    req_addr  = a;
    req_data  = d;
  endtask

  task automatic end_req();
    @(posedge clock); #3;
    req_read  = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic wait_hit(output int lat);
    lat = 0;
    forever begin
      @(negedge clock);
      if (resp_hit) break;
      lat++;
      if (lat >= 400) begin
        check("hit_timeout", resp_hit, 1'b1);
        break;
      end
    end
  endtask

  task automatic wait_mem(input bit wr, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(wr ? mem_req_write : mem_req_read) && n < 200);
    check(nm, wr ? mem_req_write : mem_req_read, 1'b1);
  endtask

  task automatic access(input logic w, input logic m, input logic [AW-1:0] a, input logic [31:0] d);
    int lat;
    start_req(w, m, a, d);
    wait_hit(lat);
    end_req();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int lat;
    logic [AW-1:0] a;
    reset = 1'b0;
    req_read = 1'b0; req_write = 1'b0; req_mode = 1'b0;
    req_addr = '0; req_data = '0;
    clear_residency();
    arch_mem[int'('h00100 >> 4)] = 128'h00000000_00000000_DEADBEEF_00000000;
    backing[int'('h00100 >> 4)]  = 128'h00000000_00000000_DEADBEEF_00000000;
    repeat (3) @(posedge clock);
    #1;
    check("rst_hit", resp_hit, 1'b0);
    check("rst_mrd", mem_req_read, 1'b0);
    check("rst_mwr", mem_req_write, 1'b0);
    check("rst_maddr", mem_req_addr, '0);
    check("rst_mdata", mem_req_data, '0);
    check("rst_rdata", resp_data, '0);
    @(posedge clock); #3;
    reset = 1'b1;

    // cold word read
    start_req(1'b0, MODE_WORD, 20'h00104, 32'h0);
    wait_mem(1'b0, "t1_fill_seen");
    check("t1_fill_addr", mem_req_addr, 20'h00100);
    wait_hit(lat);
    check("t1_data", resp_data, 32'hDEADBEEF);
    check("t1_addr", resp_addr, 20'h00104);
    end_req();

    // byte write then word read, both hitting immediately
    start_req(1'b1, MODE_BYTE, 20'h00105, 32'h000000A5);
    wait_hit(lat);
    check("t2_wr_lat", lat, 0);
    end_req();
    start_req(1'b0, MODE_WORD, 20'h00104, 32'h0);
    wait_hit(lat);
    check("t2_rd_lat", lat, 0);
    check("t2_data", resp_data, 32'hDEADA5EF);
    end_req();

    // conflicting read evicts the dirty line first
    start_req(1'b0, MODE_WORD, 20'h00140, 32'h0);
    wait_mem(1'b1, "t3_wb_seen");
    check("t3_wb_addr", mem_req_addr, 20'h00100);
    check("t3_wb_data", mem_req_data, 128'h00000000_00000000_DEADA5EF_00000000);
    wait_mem(1'b0, "t3_fill_seen");
    check("t3_fill_addr", mem_req_addr, 20'h00140);
    wait_hit(lat);
    end_req();

    // no grant: nothing issues
    bus_off = 1'b1;
    start_req(1'b0, MODE_WORD, 20'h00200, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t4_no_rd", mem_req_read, 1'b0);
      check("t4_no_hit", resp_hit, 1'b0);
    end
    bus_off = 1'b0;
    wait_mem(1'b0, "t4_fill_seen");
    check("t4_fill_addr", mem_req_addr, 20'h00200);
    wait_hit(lat);
    end_req();

    // reset while a fill is outstanding
    stall = 1'b1;
    start_req(1'b0, MODE_WORD, 20'h00300, 32'h0);
    wait_mem(1'b0, "t5_fill_seen");
    check("t5_fill_addr", mem_req_addr, 20'h00300);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_hit", resp_hit, 1'b0);
    check("t5_rst_mrd", mem_req_read, 1'b0);
    check("t5_rst_mwr", mem_req_write, 1'b0);
    check("t5_rst_maddr", mem_req_addr, '0);
    check("t5_rst_mdata", mem_req_data, '0);
    check("t5_rst_rdata", resp_data, '0);
    req_read = 1'b0;
    clear_residency();
    arch_mem[int'('h00100 >> 4)] = 128'h00000000_00000000_11223344_00000000;
    backing[int'('h00100 >> 4)]  = 128'h00000000_00000000_11223344_00000000;
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    stall = 1'b0;
    start_req(1'b0, MODE_WORD, 20'h00104, 32'h0);
    @(negedge clock);
    check("t5_post_miss", resp_hit, 1'b0);
    wait_mem(1'b0, "t5_refill_seen");
    wait_hit(lat);
    check("t5_data", resp_data, 32'h11223344);
    end_req();

    // byte read zero-extends
    start_req(1'b0, MODE_BYTE, 20'h00107, 32'h0);
    wait_hit(lat);
    check("t6_lat", lat, 0);
    check("t6_data", resp_data, 32'h00000011);
    end_req();

    // randomized traffic with an intermittent grant
    bus_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a = 20'($urandom_range(0, 'hFF));
      if ($urandom_range(0, 3) == 0) a[19] = 1'b1;
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    bus_rand = 1'b0;
    repeat (2) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_dcache.md
# cpu_dcache

Direct-mapped, write-back, write-allocate data cache between the commit stage and the shared memory bus. Serves word or byte reads and writes from the commit stage against physical addresses after translation. Reports hit/data/address combinationally. Fills and evicts whole lines over the memory bus, but only while the bus arbiter grants it.

## Interface
- ADDR_WIDTH, default `PHYSICAL_ADDR_WIDTH` (20): physical address width.
- LINE_BITS, default 128: line size, four 32-bit words.
- NUM_LINES, default 4: number of direct-mapped sets.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_read  in  1  read request; held until resp_hit.
- req_write  in  1  write request; held until resp_hit; mutually exclusive with req_read.
- req_mode  in  1  0 = word (32-bit, addr[1:0] ignored), 1 = byte (addr[1:0] selects the byte).
- req_addr  in  ADDR_WIDTH  physical byte address.
- req_data  in  32  write data; byte mode uses [7:0].
- resp_hit  out  1  the access completes this cycle.
- resp_data  out  32  read data; byte mode is zero-extended.
- resp_addr  out  ADDR_WIDTH  address of the access being answered, equal to req_addr.
- mem_bus_available  in  1  bus grant from the arbiter.
- mem_req_read  out  1  line fill request.
- mem_req_write  out  1  line write-back request.
- mem_req_addr  out  ADDR_WIDTH  line-aligned address (low 4 bits are 0).
- mem_req_data  out  LINE_BITS  evicted line.
- mem_resp_valid  in  1  memory finished the current read or write.
- mem_resp_data  in  LINE_BITS  fill data, valid when mem_resp_valid is high.

## Operation
- Address split: offset [3:0], index [5:4], tag [ADDR_WIDTH-1:6].
- Each set holds valid, dirty, tag and line.
- Hit: (req_read|req_write), valid[idx], tag match, and state IDLE.
- Read hit: resp_data is the selected word or byte, combinationally.
- Write hit: on the clock edge, the selected word or byte of the line is written and dirty is set.
- Miss in IDLE:
  - Victim dirty → WRITEBACK.
  - Victim clean or invalid → FILL.
- WRITEBACK: mem_req_write=1 with the victim's tag/index address and line, but only while mem_bus_available is high.
  - On mem_resp_valid: clear dirty, go to FILL.
- FILL: mem_req_read=1 with the line-aligned req_addr, but only while mem_bus_available is high.
  - On mem_resp_valid: install the line with valid=1, dirty=0, new tag, go to IDLE.
  - The retried access then hits.
- If mem_bus_available drops mid-transaction, request outputs drop and the state is held. The request reasserts when the grant returns.
- If req_read and req_write both drop during a miss, the in-flight transaction still completes.
- resp_hit is 0 in every state except IDLE.

## Timing
- Hit: 0-cycle latency; resp_hit is combinational in the request cycle.
- Clean miss: resp_hit in the cycle after mem_resp_valid of the fill.
- Dirty miss: write-back, then fill, then hit.
- mem_resp_valid is ignored in IDLE.
- Reset (asynchronous, any state, including mid-fill):
  - all valid and dirty bits cleared, state IDLE;
  - mem_req_read, mem_req_write and resp_hit are 0;
  - mem_req_addr, mem_req_data, resp_data are 0.
- Line contents are not required to be reset.

## Configuration
- `CPU_DCACHE_TRACE_EN`, defined: each cycle with req_read or req_write high prints address, resp_hit, resp_data, state, mem_bus_available, mem_req_read and mem_resp_valid.
- Undefined: no trace code. Functional behaviour is identical in both builds.

## Structure
- Shared package holds:
  - the state enum (IDLE, WRITEBACK, FILL);
  - the mode constants (MODE_WORD=0, MODE_BYTE=1);
  - the line-width and offset/index/tag width localparams;
  - the `PHYSICAL_ADDR_WIDTH` default.
- One sub-module: cpu_dcache_line_sel, a combinational word/byte extract for reads and merge for writes.

## Test plan
- Cold read 0x00104, word mode, bus available:
  - FILL issues mem_req_addr=0x00100;
  - respond with line word1=0xDEADBEEF;
  - next cycle resp_hit=1, resp_data=0xDEADBEEF, resp_addr=0x00104.
- Byte write 0xA5 to 0x00105 after that fill, then word read 0x00104 → 0xDEADA5EF, hit in 0 cycles.
- Read 0x00140, same index and different tag (set dirty from the previous test):
  - WRITEBACK first with mem_req_addr=0x00100 and the modified line;
  - then FILL at 0x00140.
- Hold mem_bus_available=0 for 5 cycles on a miss: mem_req_read stays 0 and resp_hit stays 0; raise it → request issues.
- Assert reset mid-FILL: outputs 0 immediately; after release, read 0x00104 misses.
- Byte read 0x00107 of line word1=0x11223344 → resp_data=0x00000011.
